accel_sequencer: RTL and testbench
==================================

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameter POWERUP_CYCLES, default 100_000, i_clk cycles to wait after reset release before first SPI command (2 ms at 50 MHz).
REQ-002 Parameter SAMPLE_PERIOD, default 500_000, i_clk cycles between read-burst starts (100 Hz at 50 MHz); legal range 64..2^20-1.
REQ-003 Parameter DATA_FORMAT_VAL, default 8'h40, value written to ADXL345 reg 0x31 (3-wire SPI, +/-2 g).
REQ-004 Parameter BW_RATE_VAL, default 8'h0A, value written to reg 0x2C.
REQ-005 Parameter POWER_CTL_VAL, default 8'h08, value written to reg 0x2D (measure mode).
REQ-006 i_clk  in  1  system clock, 50 MHz; the only clock.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 o_spi_go  out  1  transfer request to SPI controller.
REQ-009 o_read_write_n  out  1  1 = read, 0 = write; qualifies o_spi_go.
REQ-010 o_spi_data  out  16  command word {R/W, MB=0, addr[5:0], data[7:0]}.
REQ-011 i_spi_idle  in  1  SPI controller idle (chip select high).
REQ-012 i_spi_data_valid  in  1  one-cycle pulse, read byte valid.
REQ-013 i_spi_data  in  8  read byte from SPI controller.
REQ-014 o_x, o_y, o_z  out  16 each  signed two's-complement axis samples.
REQ-015 o_sample_valid  out  1  one-cycle pulse, o_x/o_y/o_z updated.
REQ-016 o_init_done  out  1  level, high once configuration writes complete.
REQ-017 o_overrun  out  1  sticky, a sample tick arrived while one was already pending.

Function
REQ-018 States: POWERUP, INIT_ISSUE, INIT_START, INIT_DONE, IDLE, RD_ISSUE, RD_START, RD_DONE, PUBLISH.
REQ-019 POWERUP: count POWERUP_CYCLES cycles, then INIT_ISSUE with init index 0.
REQ-020 Init sequence, all writes (o_read_write_n=0): index 0 -> {2'b00,6'h31,DATA_FORMAT_VAL}; 1 -> {2'b00,6'h2C,BW_RATE_VAL}; 2 -> {2'b00,6'h2D,POWER_CTL_VAL}.
REQ-021 *_ISSUE: o_spi_go=1 only while i_spi_idle=1; o_spi_data and o_read_write_n stable from ISSUE entry until *_DONE exit.
REQ-022 *_ISSUE -> *_START when i_spi_idle samples 0; o_spi_go deasserts the same cycle; o_spi_go never high in any other state.
REQ-023 *_START/*_DONE: wait for i_spi_idle to sample 1; then advance index; exactly one SPI transaction per command word.
REQ-024 After init index 2 completes: o_init_done=1 (held until reset), sample timer starts, go to IDLE.
REQ-025 Sample timer: 20-bit down-counter loaded with SAMPLE_PERIOD-1, tick when 0, reloads, free-running after init.
REQ-026 Tick sets pending flag; tick while pending already set -> o_overrun=1 (sticky until reset).
REQ-027 IDLE -> RD_ISSUE when pending=1; pending clears on that transition; byte index 0.
REQ-028 Read burst: byte index b=0..5, command {1'b1,1'b0,6'h32+b,8'h00}, o_read_write_n=1.
REQ-029 i_spi_data_valid in RD_START/RD_DONE captures i_spi_data into byte shadow b; no pulse -> shadow b keeps prior value.
REQ-030 After byte 5 completes -> PUBLISH (one cycle): o_x={b1,b0}, o_y={b3,b2}, o_z={b5,b4} updated same cycle, o_sample_valid=1 that cycle only; then IDLE.
REQ-031 Tick coincident with pending clear (IDLE->RD_ISSUE) sets pending, no overrun.
REQ-032 i_spi_data_valid outside RD_START/RD_DONE ignored.

Reset
REQ-033 i_rst_n low: immediately (asynchronously) state POWERUP, all counters/indices/pending cleared, o_spi_go=0, o_read_write_n=0, o_spi_data=0, o_x=o_y=o_z=0, o_sample_valid=0, o_init_done=0, o_overrun=0.
REQ-034 Reset mid-transaction aborts it; after release full POWERUP + init sequence reruns.

Verification (POWERUP_CYCLES=10, SAMPLE_PERIOD=200, bench SPI model)
REQ-035 Reset release -> ~10 cycles later writes 16'h3140, 16'h2C0A, 16'h2D08 in order, rw=0; o_init_done rises after third idle return.
REQ-036 Model returns 34,12,CD,AB,01,80 (hex) -> commands 16'hB200..16'hB700, rw=1; o_x=16'h1234, o_y=16'hABCD, o_z=16'h8001, single o_sample_valid pulse.
REQ-037 Successive bursts: RD_ISSUE entries 200 cycles apart; o_overrun stays 0.
REQ-038 Model stretches transfers so burst > 400 cycles -> o_overrun=1 and stays; next burst issues immediately after PUBLISH.
REQ-039 Model delays idle fall 3 cycles after go -> o_spi_go high and o_spi_data stable all 3 cycles; one transaction per word.
REQ-040 Assert i_rst_n=0 during byte 3 -> all outputs 0 same cycle; after release init writes repeat before any read.

Source files
------------

// File: rtl/accel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : accel_sequencer
// Brief    : Powers up and configures an ADXL345 over SPI, then reads the
//            six axis data registers once per sample period.
// Revision : 1.0 - initial release
// ============================================================================
module accel_sequencer #(
    parameter int         POWERUP_CYCLES  = 100_000,
    parameter int         SAMPLE_PERIOD   = 500_000,
    parameter logic [7:0] DATA_FORMAT_VAL = 8'h40,
    parameter logic [7:0] BW_RATE_VAL     = 8'h0A,
    parameter logic [7:0] POWER_CTL_VAL   = 8'h08
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_spi_go,
    output logic        o_read_write_n,
    output logic [15:0] o_spi_data,
    input  logic        i_spi_idle,
    input  logic        i_spi_data_valid,
    input  logic [7:0]  i_spi_data,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic [15:0] o_z,
    output logic        o_sample_valid,
    output logic        o_init_done,
    output logic        o_overrun
);

    localparam int                c_PU_W     = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam logic [c_PU_W-1:0] c_PU_LAST  = c_PU_W'(POWERUP_CYCLES - 1);
    localparam logic [19:0]       c_TMR_LAST = 20'(SAMPLE_PERIOD - 1);
    localparam logic [2:0]        c_INIT_LAST = 3'd2;
    localparam logic [2:0]        c_BYTE_LAST = 3'd5;

    typedef enum logic [3:0] {
        S_POWERUP    = 4'd0,
        S_INIT_ISSUE = 4'd1,
        S_INIT_START = 4'd2,
        S_INIT_DONE  = 4'd3,
        S_IDLE       = 4'd4,
        S_RD_ISSUE   = 4'd5,
        S_RD_START   = 4'd6,
        S_RD_DONE    = 4'd7,
        S_PUBLISH    = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PU_W-1:0]   r_pu_cnt;
    logic [2:0]          r_idx;
    logic [19:0]         r_tmr;
    logic                r_tmr_en;
    logic                r_pending;
    logic [5:0][7:0]     r_shadow;
    logic [5:0][7:0]     w_shadow_nxt;
    logic                w_tick;
    logic                w_take;
    logic                w_capture;
    logic                w_init_fin;
    logic                w_burst_fin;
    logic [5:0]          w_rd_addr;
    logic [15:0]         w_init_word;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_POWERUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_POWERUP:    if (r_pu_cnt == c_PU_LAST) w_state_nxt = S_INIT_ISSUE;
            S_INIT_ISSUE: if (!i_spi_idle)           w_state_nxt = S_INIT_START;
            S_INIT_START: if (i_spi_idle)            w_state_nxt = S_INIT_DONE;
            S_INIT_DONE:  w_state_nxt = (r_idx == c_INIT_LAST) ? S_IDLE : S_INIT_ISSUE;
            S_IDLE:       if (r_pending)             w_state_nxt = S_RD_ISSUE;
            S_RD_ISSUE:   if (!i_spi_idle)           w_state_nxt = S_RD_START;
            S_RD_START:   if (i_spi_idle)            w_state_nxt = S_RD_DONE;
            S_RD_DONE:    w_state_nxt = (r_idx == c_BYTE_LAST) ? S_PUBLISH : S_RD_ISSUE;
            S_PUBLISH:    w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_POWERUP;
        endcase
    end

    // ------------------------------------------------------------------
    // Command word and handshake outputs, derived from state and index
    // ------------------------------------------------------------------
    assign w_rd_addr = 6'h32 + {3'b000, r_idx};

    always_comb begin
        w_init_word = {2'b00, 6'h31, DATA_FORMAT_VAL};
        case (r_idx)
            3'd1:    w_init_word = {2'b00, 6'h2C, BW_RATE_VAL};
            3'd2:    w_init_word = {2'b00, 6'h2D, POWER_CTL_VAL};
            default: w_init_word = {2'b00, 6'h31, DATA_FORMAT_VAL};
        endcase
    end

    always_comb begin
        o_spi_go       = 1'b0;
        o_read_write_n = 1'b0;
        o_spi_data     = 16'h0000;
        o_sample_valid = 1'b0;
        case (r_state)
            S_INIT_ISSUE: begin
                o_spi_go   = i_spi_idle;
                o_spi_data = w_init_word;
            end
            S_INIT_START, S_INIT_DONE: begin
                o_spi_data = w_init_word;
            end
            S_RD_ISSUE: begin
                o_spi_go       = i_spi_idle;
                o_read_write_n = 1'b1;
                o_spi_data     = {1'b1, 1'b0, w_rd_addr, 8'h00};
            end
            S_RD_START, S_RD_DONE: begin
                o_read_write_n = 1'b1;
                o_spi_data     = {1'b1, 1'b0, w_rd_addr, 8'h00};
            end
            S_PUBLISH: begin
                o_sample_valid = 1'b1;
            end
            default: begin
                o_spi_go = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte capture: the last byte may arrive in the same cycle the burst
    // finishes, so the published value is taken from the next-shadow view.
    // ------------------------------------------------------------------
    assign w_capture = i_spi_data_valid && ((r_state == S_RD_START) || (r_state == S_RD_DONE));

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_capture) begin
            for (int b = 0; b < 6; b++) begin
                if (r_idx == 3'(b)) begin
                    w_shadow_nxt[b] = i_spi_data;
                end
            end
        end
    end

    assign w_init_fin  = (r_state == S_INIT_DONE) && (r_idx == c_INIT_LAST);
    assign w_burst_fin = (r_state == S_RD_DONE) && (r_idx == c_BYTE_LAST);
    assign w_tick      = r_tmr_en && (r_tmr == 20'd0);
    assign w_take      = (r_state == S_IDLE) && r_pending;

    // ------------------------------------------------------------------
    // Counters, indices, sample timer and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pu_cnt    <= '0;
            r_idx       <= 3'd0;
            r_tmr       <= 20'd0;
            r_tmr_en    <= 1'b0;
            r_pending   <= 1'b0;
            r_shadow    <= '0;
            o_x         <= 16'h0000;
            o_y         <= 16'h0000;
            o_z         <= 16'h0000;
            o_init_done <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (r_state == S_POWERUP) begin
                r_pu_cnt <= r_pu_cnt + 1'b1;
            end else begin
                r_pu_cnt <= '0;
            end

            if (r_state == S_INIT_DONE) begin
                r_idx <= w_init_fin ? 3'd0 : r_idx + 3'd1;
            end else if (r_state == S_RD_DONE) begin
                r_idx <= w_burst_fin ? 3'd0 : r_idx + 3'd1;
            end else if (r_state == S_IDLE || r_state == S_POWERUP) begin
                r_idx <= 3'd0;
            end

            if (w_init_fin) begin
                o_init_done <= 1'b1;
                r_tmr_en    <= 1'b1;
                r_tmr       <= c_TMR_LAST;
            end else if (r_tmr_en) begin
                r_tmr <= (r_tmr == 20'd0) ? c_TMR_LAST : r_tmr - 20'd1;
            end

            // A tick landing on the same edge the pending request is consumed
            // re-arms the request rather than counting as an overrun.
            if (w_tick) begin
                if (r_pending && !w_take) begin
                    o_overrun <= 1'b1;
                end
                r_pending <= 1'b1;
            end else if (w_take) begin
                r_pending <= 1'b0;
            end

            r_shadow <= w_shadow_nxt;

            if (w_burst_fin) begin
                o_x <= {w_shadow_nxt[1], w_shadow_nxt[0]};
                o_y <= {w_shadow_nxt[3], w_shadow_nxt[2]};
                o_z <= {w_shadow_nxt[5], w_shadow_nxt[4]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_sequencer
// Brief    : Scoreboard bench for accel_sequencer with a behavioural SPI
//            controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accel_sequencer;

    localparam int c_PU = 10;
    localparam int c_SP = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_go;
    logic        read_write_n;
    logic [15:0] spi_data;
    logic        spi_idle;
    logic        spi_dv;
    logic [7:0]  spi_rdata;
    logic [15:0] x_val, y_val, z_val;
    logic        sample_valid;
    logic        init_done;
    logic        overrun;

    accel_sequencer #(
        .POWERUP_CYCLES (c_PU),
        .SAMPLE_PERIOD  (c_SP)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_spi_go         (spi_go),
        .o_read_write_n   (read_write_n),
        .o_spi_data       (spi_data),
        .i_spi_idle       (spi_idle),
        .i_spi_data_valid (spi_dv),
        .i_spi_data       (spi_rdata),
        .o_x              (x_val),
        .o_y              (y_val),
        .o_z              (z_val),
        .o_sample_valid   (sample_valid),
        .o_init_done      (init_done),
        .o_overrun        (overrun)
    );

    always #10 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          n_samples = 0;
    logic [16:0] exp_cmd[$];
    logic [47:0] exp_smp[$];
    int          rd_cyc[$];
    int          pub_cyc[$];
    logic [7:0]  tbl[6];
    logic [5:0]  skip = 6'b0;
    int          fall_delay = 0;
    int          xfer_len = 2;
    int          cur_byte = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_go"},   32'(spi_go), 32'd0);
        check_eq({tag, "_rw"},   32'(read_write_n), 32'd0);
        check_eq({tag, "_data"}, 32'(spi_data), 32'd0);
        check_eq({tag, "_x"},    32'(x_val), 32'd0);
        check_eq({tag, "_y"},    32'(y_val), 32'd0);
        check_eq({tag, "_z"},    32'(z_val), 32'd0);
        check_eq({tag, "_sv"},   32'(sample_valid), 32'd0);
        check_eq({tag, "_done"}, 32'(init_done), 32'd0);
        check_eq({tag, "_ovr"},  32'(overrun), 32'd0);
    endtask

    task automatic push_init();
        exp_cmd.push_back(17'h03140);
        exp_cmd.push_back(17'h02C0A);
        exp_cmd.push_back(17'h02D08);
    endtask

    task automatic push_burst(input logic [47:0] smp);
        for (int b = 0; b < 6; b++) begin
            exp_cmd.push_back({1'b1, 1'b1, 1'b0, 6'(6'h32 + b), 8'h00});
        end
        exp_smp.push_back(smp);
    endtask

    task automatic wait_samples(input int target, input int budget);
        int n;
        n = 0;
        while (n_samples < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("sample_timeout", 32'(n_samples >= target), 32'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // SPI controller model: accepts a go, optionally holds idle high for a
    // few cycles, then runs a transfer and returns the table byte for reads.
    initial begin
        logic [15:0] cmd;
        logic        rw;
        logic [16:0] e;
        int          b;
        spi_idle  = 1'b1;
        spi_dv    = 1'b0;
        spi_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            spi_dv = 1'b0;
            if (rst_n && spi_go && spi_idle) begin
                cmd = spi_data;
                rw  = read_write_n;
                if (rw && cmd == 16'hB200) rd_cyc.push_back(cyc);
                for (int k = 0; k < fall_delay; k++) begin
                    @(posedge clk); #1;
                    check_eq("go_held", 32'(spi_go), 32'd1);
                    check_eq("data_stable", 32'(spi_data), 32'(cmd));
                end
                spi_idle = 1'b0;
                if (exp_cmd.size() == 0) begin
                    check_eq("cmd_extra", 32'(exp_cmd.size()), 32'd1);
                end else begin
                    e = exp_cmd.pop_front();
                    check_eq("cmd", 32'({rw, cmd}), 32'(e));
                end
                b = int'(cmd[13:8]) - 32'h32;
                cur_byte = rw ? b : -1;
                for (int k = 0; k < xfer_len; k++) begin
                    @(posedge clk); #1;
                end
                if (rw && b >= 0 && b < 6 && !skip[b]) begin
                    spi_dv    = 1'b1;
                    spi_rdata = tbl[b];
                end
                @(posedge clk); #1;
                spi_dv   = 1'b0;
                spi_idle = 1'b1;
                cur_byte = -1;
            end
        end
    end

    // Output monitor: go never high while busy, samples match scoreboard.
    initial begin
        logic        prev_sv;
        logic [47:0] s;
        prev_sv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && spi_go) check_eq("go_while_busy", 32'(spi_idle), 32'd1);
            if (sample_valid) begin
                if (prev_sv) check_eq("sv_pulse_width", 32'(prev_sv), 32'd0);
                pub_cyc.push_back(cyc);
                n_samples++;
                if (exp_smp.size() == 0) begin
                    check_eq("smp_extra", 32'(exp_smp.size()), 32'd1);
                end else begin
                    s = exp_smp.pop_front();
                    check_eq("x", 32'(x_val), 32'(s[47:32]));
                    check_eq("y", 32'(y_val), 32'(s[31:16]));
                    check_eq("z", 32'(z_val), 32'(s[15:0]));
                end
            end
            prev_sv = sample_valid;
        end
    end

    initial begin
        int n;
        tbl = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");

        push_init();
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("init_early", 32'(init_done), 32'd0);
        end
        n = 0;
        while (!init_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("init_done", 32'(init_done), 32'd1);
        check_eq("init_writes_left", 32'(exp_cmd.size()), 32'd0);

        push_burst({16'h1234, 16'hABCD, 16'h8001});
        wait_samples(1, 600);

        tbl = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h55, 8'hAA};
        push_burst({16'h7FFF, 16'h8000, 16'hAA55});
        wait_samples(2, 600);

        // Byte 4 never pulses valid, so the previous low Z byte is retained.
        tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'h66};
        skip = 6'b010000;
        fall_delay = 3;
        push_burst({16'h2211, 16'h4433, 16'h6655});
        wait_samples(3, 600);
        check_eq("period_1", 32'(rd_cyc[1] - rd_cyc[0]), 32'(c_SP));
        check_eq("period_2", 32'(rd_cyc[2] - rd_cyc[1]), 32'(c_SP));
        check_eq("no_overrun", 32'(overrun), 32'd0);

        fall_delay = 0;
        skip = 6'b0;
        tbl = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
        xfer_len = 80;
        push_burst({16'h1234, 16'hABCD, 16'h8001});
        push_burst({16'h1234, 16'hABCD, 16'h8001});
        wait_samples(4, 2000);
        check_eq("overrun_set", 32'(overrun), 32'd1);
        wait_samples(5, 2000);
        check_eq("back_to_back_gap", 32'(rd_cyc[4] - pub_cyc[3]), 32'd2);
        check_eq("overrun_sticky", 32'(overrun), 32'd1);

        xfer_len = 2;
        push_burst({16'h1234, 16'hABCD, 16'h8001});
        n = 0;
        while (!(cur_byte == 3 && !spi_idle) && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check_eq("reached_byte3", 32'(cur_byte), 32'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        exp_cmd.delete();
        exp_smp.delete();
        push_init();
        push_burst({16'h1234, 16'hABCD, 16'h8001});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_samples(6, 1500);
        check_eq("rerun_cmds_left", 32'(exp_cmd.size()), 32'd0);
        check_eq("rerun_overrun", 32'(overrun), 32'd0);
        check_eq("rerun_init_done", 32'(init_done), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
